_5bit_or_checker: RTL

Self-checking response monitor for the 5-bit logic units. It receives operand pairs together with the DUT's result and recomputes the expected AND/OR/XOR/NOR value. After a fixed pipeline latency it compares the DUT result against that expectation and keeps pass/fail statistics. It is the receiving end of the operand-stimulus interface that drives `_5bit_or` and sibling gates, and lets the same vector sequences run on hardware without a `$monitor`.

---
 rtl/alu5_pkg.sv | 22 ++
 rtl/_5bit_logic_ref.sv | 24 ++
 rtl/_5bit_or_checker.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu5_pkg.sv
// Shared definitions for the 5-bit logic-unit family: operand width,
// operation encodings and the response-checker session states.
package alu5_pkg;

  localparam int unsigned WIDTH       = 5;
  localparam int unsigned LATENCY_MAX = 4;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/_5bit_logic_ref.sv
// Combinational golden model of the 5-bit logic units: the AND/OR/XOR/NOR
// result the unit under test is expected to produce for one operand pair.
module _5bit_logic_ref #(
  parameter int unsigned WIDTH = alu5_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] inp_a,
  input  logic [WIDTH-1:0] inp_b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] expected
);
  import alu5_pkg::*;

  always_comb begin
    expected = '0;
    unique case (op)
      OP_AND:  expected = inp_a & inp_b;
      OP_OR:   expected = inp_a | inp_b;
      OP_XOR:  expected = inp_a ^ inp_b;
      OP_NOR:  expected = ~(inp_a | inp_b);
      default: expected = '0;
    endcase
  end

endmodule

// File: rtl/_5bit_or_checker.sv
// Response monitor for the 5-bit logic units: recomputes each accepted
// vector's result, compares it LATENCY cycles later and keeps statistics.
module _5bit_or_checker #(
  parameter int unsigned WIDTH   = alu5_pkg::WIDTH,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic             vec_last,
  input  logic [WIDTH-1:0] inp_a,
  input  logic [WIDTH-1:0] inp_b,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] mismatch_bits
);
  import alu5_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e             state_q, state_d;

  logic [WIDTH-1:0]   exp_pipe_q [LATENCY];
  logic [WIDTH-1:0]   exp_pipe_d [LATENCY];
  logic [CNT_W-1:0]   idx_pipe_q [LATENCY];
  logic [CNT_W-1:0]   idx_pipe_d [LATENCY];
  logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;

  logic [CNT_W-1:0]   vec_idx_q, vec_idx_d;
  logic [CNT_W-1:0]   pass_q, pass_d;
  logic [CNT_W-1:0]   fail_q, fail_d;
  logic               ff_valid_q, ff_valid_d;
  logic [CNT_W-1:0]   ff_idx_q, ff_idx_d;
  logic [WIDTH-1:0]   mism_q, mism_d;

  logic [WIDTH-1:0]   expected;
  logic               accept;
  logic               clear;
  logic               cmp_valid;
  logic [WIDTH-1:0]   cmp_diff;

  _5bit_logic_ref #(
    .WIDTH(WIDTH)
  ) u_ref (
    .inp_a    (inp_a),
    .inp_b    (inp_b),
    .op       (op),
    .expected (expected)
  );

  assign vec_ready = (state_q == ST_RUN);
  assign accept    = vec_valid && vec_ready;
  assign clear     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign cmp_valid = vld_pipe_q[LATENCY-1];
  assign cmp_diff  = exp_pipe_q[LATENCY-1] ^ dut_out;

  // Stage 0 takes the new vector; the last stage is the one being compared
  // on this edge, so it never appears in the _d image.
  always_comb begin
    exp_pipe_d    = exp_pipe_q;
    idx_pipe_d    = idx_pipe_q;
    vld_pipe_d    = vld_pipe_q;
    exp_pipe_d[0] = expected;
    idx_pipe_d[0] = vec_idx_q;
    vld_pipe_d[0] = accept;
    for (int unsigned k = 1; k < LATENCY; k++) begin
      exp_pipe_d[k] = exp_pipe_q[k-1];
      idx_pipe_d[k] = idx_pipe_q[k-1];
      vld_pipe_d[k] = vld_pipe_q[k-1];
    end
    if (clear) begin
      vld_pipe_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (accept && vec_last) state_d = ST_DRAIN;
      ST_DRAIN: if (vld_pipe_d == '0) state_d = ST_DONE;
      ST_DONE:  if (start) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vec_idx_d  = vec_idx_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    ff_valid_d = ff_valid_q;
    ff_idx_d   = ff_idx_q;
    mism_d     = mism_q;
    if (clear) begin
      vec_idx_d  = '0;
      pass_d     = '0;
      fail_d     = '0;
      ff_valid_d = 1'b0;
      ff_idx_d   = '0;
      mism_d     = '0;
    end else begin
      if (accept) begin
        vec_idx_d = vec_idx_q + CNT_ONE;
      end
      if (cmp_valid) begin
        if (cmp_diff == '0) begin
          if (pass_q != CNT_MAX) pass_d = pass_q + CNT_ONE;
        end else begin
          if (fail_q != CNT_MAX) fail_d = fail_q + CNT_ONE;
          if (!ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_idx_d   = idx_pipe_q[LATENCY-1];
            mism_d     = cmp_diff;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      exp_pipe_q <= '{default: '0};
      idx_pipe_q <= '{default: '0};
      vld_pipe_q <= '0;
      vec_idx_q  <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      ff_valid_q <= 1'b0;
      ff_idx_q   <= '0;
      mism_q     <= '0;
    end else begin
      state_q    <= state_d;
      exp_pipe_q <= exp_pipe_d;
      idx_pipe_q <= idx_pipe_d;
      vld_pipe_q <= vld_pipe_d;
      vec_idx_q  <= vec_idx_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      ff_valid_q <= ff_valid_d;
      ff_idx_q   <= ff_idx_d;
      mism_q     <= mism_d;
    end
  end

  assign busy             = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done             = (state_q == ST_DONE);
  assign pass_count       = pass_q;
  assign fail_count       = fail_q;
  assign first_fail_valid = ff_valid_q;
  assign first_fail_idx   = ff_idx_q;
  assign mismatch_bits    = mism_q;

endmodule
